or1200_ifetch_resp: RTL and testbench
=====================================

# or1200_ifetch_resp

Instruction-fetch responder on the CPU side of the instruction bus. It answers fetch requests from the IF stage with `icpu_dat_o`/`icpu_ack_o`/`icpu_err_o`/`icpu_adr_o`/`icpu_tag_o`, sourcing words from a Wishbone classic read master or from a one-word last-fetch buffer. It adds retry handling, a bus timeout that converts hangs into bus errors, and abort draining. It sits between the IF stage and the instruction Wishbone port whenever the instruction cache is not used.

## Interface
- `TIMEOUT_CYCLES`, default 255: bus cycles allowed per fetch before a forced error. Range 0..255; 0 disables the timeout.
- `BUF_EN`, default 1: enables the last-fetch buffer. When 0, every fetch goes to the bus.
- `clk` in 1: single clock, all logic on the rising edge.
- `rst` in 1: reset, asynchronous assert, active-low.
- `icpu_cycstb_i` in 1: fetch request. Held with `icpu_adr_i` until ack or err.
- `icpu_adr_i` in 32: fetch address. Bits [1:0] are ignored.
- `icpu_tag_i` in 4: request tag. Not used for decoding; reserved.
- `icpu_inv_i` in 1: one-cycle pulse that invalidates the last-fetch buffer.
- `icpu_dat_o` out 32: returned instruction.
- `icpu_ack_o` out 1: one-cycle pulse, fetch data valid.
- `icpu_err_o` out 1: one-cycle pulse, fetch failed.
- `icpu_adr_o` out 32: word address of the returned fetch, {adr[31:2],2'b00}.
- `icpu_tag_o` out 4: 4'h1 (NI) with ack, 4'hb (BE) with err, otherwise 4'h0.
- `iwb_cyc_o` out 1: Wishbone cycle.
- `iwb_stb_o` out 1: Wishbone strobe.
- `iwb_adr_o` out 32: bus address; bits [1:0] are always 0.
- `iwb_sel_o` out 4: 4'hf during a cycle, else 0.
- `iwb_we_o` out 1: constant 0.
- `iwb_cti_o` out 3: constant 3'b000.
- `iwb_dat_i` in 32: read data.
- `iwb_ack_i` in 1: transfer acknowledge.
- `iwb_err_i` in 1: transfer error.
- `iwb_rty_i` in 1: transfer retry.

## Operation
- All outputs are registered.
- Reset values: every output is 0; state is IDLE; buffer is invalid; timeout counter is 0.
- FSM states: IDLE, BUS, RETRY, DRAIN, RESP.
- **IDLE**, with `icpu_cycstb_i` asserted:
  - Buffer hit (BUF_EN, buffer valid, adr[31:2] equals buffered adr[31:2], no `icpu_inv_i` this cycle): load outputs from the buffer and go to RESP.
  - Otherwise: latch the address, assert cyc/stb/sel and go to BUS.
- **BUS**, the Wishbone slave response decides the next state. Priority is err > ack > rty.
  - `iwb_ack_i`: capture data, drop cyc/stb, go to RESP with ack and tag NI. The buffer is written with {adr, data} and set valid, unless `icpu_inv_i` was seen at any point during this fetch.
  - `iwb_err_i`: drop cyc/stb, go to RESP with err and tag BE, `icpu_dat_o`=0, buffer invalidated.
  - `iwb_rty_i`: drop stb only (cyc stays high) and go to RETRY.
  - `icpu_cycstb_i` low (abort): go to DRAIN, keeping cyc/stb.
- **RETRY**: lasts one cycle with stb low, then reasserts stb and returns to BUS. The timeout counter is not cleared.
- **DRAIN**:
  - Stays on the bus until ack, err, rty or timeout.
  - Then drops cyc/stb and returns to IDLE with no CPU ack/err. The buffer is not updated.
- **RESP**:
  - `icpu_ack_o` or `icpu_err_o` is high for exactly this cycle; `icpu_adr_o`/`icpu_tag_o` are valid alongside it.
  - Next state is IDLE. A new request is never started in the RESP cycle.
- **Timeout**:
  - The counter increments every cycle in BUS/RETRY/DRAIN and clears on entering IDLE.
  - When it reaches TIMEOUT_CYCLES, cyc/stb drop.
  - From BUS/RETRY: go to RESP with err and tag BE, buffer invalidated.
  - From DRAIN: go to IDLE silently.
- `icpu_inv_i` in any state clears the buffer-valid bit. A simultaneous buffer write in the same cycle loses to the invalidate.
- `rst` asserted mid-cycle: cyc/stb drop asynchronously and any pending ack is lost.

## Timing
- Buffer hit: request seen at edge 0, ack high in cycle 1. Latency 1.
- Bus path with a zero-wait slave: cyc/stb high in cycle 1, slave ack in cycle 1, `icpu_ack_o` in cycle 2. Latency 2; each slave wait state adds 1.
- Each retry adds 2 cycles: the RETRY cycle plus a fresh BUS cycle.
- Back-to-back fetches: the earliest next cyc is 2 cycles after RESP (RESP, IDLE decode, BUS).
- Timeout with TIMEOUT_CYCLES=N: err in cycle N+1 after cyc first rises.
- Ack/err pulses are never longer than 1 cycle, and ack and err are never both high.

## Test plan
- Miss then hit:
  - Fetch 0x100 with the slave returning 0x15000000 after 0 waits: ack in cycle 2, adr_o=0x100, tag 1.
  - Refetch 0x100: ack 1 cycle after the request, no cyc.
- Invalidate:
  - Pulse `icpu_inv_i`, then fetch 0x100: goes to the bus, ack latency 2.
  - `icpu_inv_i` during an outstanding fetch of 0x200: that fetch completes, and an immediate refetch of 0x200 misses.
- Error/retry:
  - Slave asserts rty once, then ack: stb low for exactly 1 cycle, cyc held, ack latency 4.
  - Slave asserts err: `icpu_err_o`=1, tag 4'hb, dat 0, buffer invalid.
- Timeout:
  - TIMEOUT_CYCLES=4, slave silent: cyc drops and err appears in cycle 5.
  - TIMEOUT_CYCLES=0 with the slave silent for 300 cycles: no err.
- Abort:
  - Drop cycstb in BUS while the slave is waiting, slave acks 3 cycles later: no `icpu_ack_o`, cyc drops after the ack.
  - A following fetch of the same address misses.
- Reset: `rst` low during BUS puts cyc/stb/ack/err at 0 the same cycle and invalidates the buffer; after release, fetch 0x100 goes to the bus.

Source files
------------

// File: rtl/or1200_ifetch_resp.sv
// Instruction-fetch responder: serves IF-stage fetches from a one-word
// last-fetch buffer or a Wishbone classic read. Adds retry handling, a
// bus timeout that turns hangs into errors, and abort draining.
module or1200_ifetch_resp #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter bit          BUF_EN         = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        icpu_cycstb_i,
  input  logic [31:0] icpu_adr_i,
  input  logic [3:0]  icpu_tag_i,
  input  logic        icpu_inv_i,
  output logic [31:0] icpu_dat_o,
  output logic        icpu_ack_o,
  output logic        icpu_err_o,
  output logic [31:0] icpu_adr_o,
  output logic [3:0]  icpu_tag_o,
  output logic        iwb_cyc_o,
  output logic        iwb_stb_o,
  output logic [31:0] iwb_adr_o,
  output logic [3:0]  iwb_sel_o,
  output logic        iwb_we_o,
  output logic [2:0]  iwb_cti_o,
  input  logic [31:0] iwb_dat_i,
  input  logic        iwb_ack_i,
  input  logic        iwb_err_i,
  input  logic        iwb_rty_i
);

  localparam int unsigned WORD_W = 30;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned CNT_EW = CNT_W + 1;

  localparam logic [3:0]        TAG_NI   = 4'h1;
  localparam logic [3:0]        TAG_BE   = 4'hb;
  localparam logic [CNT_EW-1:0] TO_LIMIT = CNT_EW'(TIMEOUT_CYCLES);
  localparam bit                TO_ON    = (TIMEOUT_CYCLES != 0);

  typedef enum logic [2:0] {IDLE, BUS, RETRY, DRAIN, RESP} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_step;
  logic [CNT_EW-1:0]   cnt_plus;
  logic                timeout_hit;
  logic                inv_seen_q, inv_seen_d;
  logic                buf_valid_q, buf_valid_d;
  logic [WORD_W-1:0]   buf_adr_q, buf_adr_d;
  logic [DATA_W-1:0]   buf_dat_q, buf_dat_d;
  logic                buf_hit;

  logic [DATA_W-1:0]   dat_d;
  logic                ack_d, err_d;
  logic [31:0]         adr_d;
  logic [3:0]          tag_d;
  logic                cyc_d, stb_d;
  logic [31:0]         wadr_d;
  logic [3:0]          sel_d;

  // Tag and the byte-offset bits carry no meaning for a word fetch.
  logic unused_bits;
  assign unused_bits = ^{icpu_tag_i, icpu_adr_i[1:0]};

  // Read-only instruction port, classic cycles only.
  assign iwb_we_o  = 1'b0;
  assign iwb_cti_o = 3'b000;

  // Next-state, next-output and buffer update decode.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    inv_seen_d  = inv_seen_q | icpu_inv_i;
    buf_valid_d = buf_valid_q;
    buf_adr_d   = buf_adr_q;
    buf_dat_d   = buf_dat_q;
    dat_d       = icpu_dat_o;
    ack_d       = 1'b0;
    err_d       = 1'b0;
    adr_d       = icpu_adr_o;
    tag_d       = 4'h0;
    cyc_d       = iwb_cyc_o;
    stb_d       = iwb_stb_o;
    wadr_d      = iwb_adr_o;
    sel_d       = iwb_sel_o;

    cnt_plus    = CNT_EW'(cnt_q) + CNT_EW'(1);
    timeout_hit = TO_ON && (cnt_plus >= TO_LIMIT);
    cnt_step    = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
    buf_hit     = BUF_EN && buf_valid_q && !icpu_inv_i &&
                  (buf_adr_q == icpu_adr_i[31:2]);

    unique case (state_q)
      IDLE: begin
        cnt_d      = '0;
        inv_seen_d = icpu_inv_i;
        if (icpu_cycstb_i) begin
          if (buf_hit) begin
            dat_d   = buf_dat_q;
            adr_d   = {buf_adr_q, 2'b00};
            ack_d   = 1'b1;
            tag_d   = TAG_NI;
            state_d = RESP;
          end else begin
            wadr_d  = {icpu_adr_i[31:2], 2'b00};
            cyc_d   = 1'b1;
            stb_d   = 1'b1;
            sel_d   = 4'hf;
            state_d = BUS;
          end
        end
      end

      BUS: begin
        cnt_d = cnt_step;
        if (iwb_err_i || iwb_ack_i || (timeout_hit && !iwb_rty_i && icpu_cycstb_i)) begin
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          sel_d   = 4'h0;
          adr_d   = iwb_adr_o;
          state_d = RESP;
          if (!iwb_err_i && iwb_ack_i) begin
            dat_d = iwb_dat_i;
            ack_d = 1'b1;
            tag_d = TAG_NI;
            if (BUF_EN && !inv_seen_d) begin
              buf_valid_d = 1'b1;
              buf_adr_d   = iwb_adr_o[31:2];
              buf_dat_d   = iwb_dat_i;
            end
          end else begin
            dat_d       = '0;
            err_d       = 1'b1;
            tag_d       = TAG_BE;
            buf_valid_d = 1'b0;
          end
        end else if (iwb_rty_i) begin
          stb_d   = 1'b0;
          state_d = RETRY;
        end else if (!icpu_cycstb_i) begin
          state_d = DRAIN;
        end
      end

      RETRY: begin
        cnt_d = cnt_step;
        if (timeout_hit) begin
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          sel_d       = 4'h0;
          adr_d       = iwb_adr_o;
          dat_d       = '0;
          err_d       = 1'b1;
          tag_d       = TAG_BE;
          buf_valid_d = 1'b0;
          state_d     = RESP;
        end else begin
          stb_d   = 1'b1;
          state_d = BUS;
        end
      end

      DRAIN: begin
        cnt_d = cnt_step;
        if (iwb_ack_i || iwb_err_i || iwb_rty_i || timeout_hit) begin
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          sel_d   = 4'h0;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end

      RESP: begin
        cnt_d   = '0;
        state_d = IDLE;
      end

      default: begin
        cyc_d   = 1'b0;
        stb_d   = 1'b0;
        sel_d   = 4'h0;
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase

    // An invalidate always beats a same-cycle buffer fill.
    if (icpu_inv_i) buf_valid_d = 1'b0;
  end

  // State, counter, buffer and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      inv_seen_q  <= 1'b0;
      buf_valid_q <= 1'b0;
      buf_adr_q   <= '0;
      buf_dat_q   <= '0;
      icpu_dat_o  <= '0;
      icpu_ack_o  <= 1'b0;
      icpu_err_o  <= 1'b0;
      icpu_adr_o  <= '0;
      icpu_tag_o  <= 4'h0;
      iwb_cyc_o   <= 1'b0;
      iwb_stb_o   <= 1'b0;
      iwb_adr_o   <= '0;
      iwb_sel_o   <= 4'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      inv_seen_q  <= inv_seen_d;
      buf_valid_q <= buf_valid_d;
      buf_adr_q   <= buf_adr_d;
      buf_dat_q   <= buf_dat_d;
      icpu_dat_o  <= dat_d;
      icpu_ack_o  <= ack_d;
      icpu_err_o  <= err_d;
      icpu_adr_o  <= adr_d;
      icpu_tag_o  <= tag_d;
      iwb_cyc_o   <= cyc_d;
      iwb_stb_o   <= stb_d;
      iwb_adr_o   <= wadr_d;
      iwb_sel_o   <= sel_d;
    end
  end

endmodule

// File: tb/tb_or1200_ifetch_resp.sv
// Bench for or1200_ifetch_resp: directed scenarios plus a randomized run
// checked against a buffer/latency model of the fetch protocol.
module tb_or1200_ifetch_resp;

  localparam int unsigned TO1 = 4;

  logic        clk;
  logic        rst;
  logic        cycstb;
  logic [31:0] adr;
  logic [3:0]  tag;
  logic        inv;
  logic [31:0] wb_dat;
  logic        wb_ack, wb_err, wb_rty;

  logic [31:0] d0_dat, d1_dat, d2_dat, d0_adr, d1_adr, d2_adr;
  logic        d0_ack, d1_ack, d2_ack, d0_err, d1_err, d2_err;
  logic [3:0]  d0_tag, d1_tag, d2_tag, d0_sel, d1_sel, d2_sel;
  logic        d0_cyc, d1_cyc, d2_cyc, d0_stb, d1_stb, d2_stb;
  logic [31:0] d0_wadr, d1_wadr, d2_wadr;
  logic        d0_we, d1_we, d2_we;
  logic [2:0]  d0_cti, d1_cti, d2_cti;

  or1200_ifetch_resp dut0 (
    .clk(clk), .rst(rst), .icpu_cycstb_i(cycstb), .icpu_adr_i(adr), .icpu_tag_i(tag),
    .icpu_inv_i(inv), .icpu_dat_o(d0_dat), .icpu_ack_o(d0_ack), .icpu_err_o(d0_err),
    .icpu_adr_o(d0_adr), .icpu_tag_o(d0_tag), .iwb_cyc_o(d0_cyc), .iwb_stb_o(d0_stb),
    .iwb_adr_o(d0_wadr), .iwb_sel_o(d0_sel), .iwb_we_o(d0_we), .iwb_cti_o(d0_cti),
    .iwb_dat_i(wb_dat), .iwb_ack_i(wb_ack), .iwb_err_i(wb_err), .iwb_rty_i(wb_rty));

  or1200_ifetch_resp #(.TIMEOUT_CYCLES(TO1)) dut1 (
    .clk(clk), .rst(rst), .icpu_cycstb_i(cycstb), .icpu_adr_i(adr), .icpu_tag_i(tag),
    .icpu_inv_i(inv), .icpu_dat_o(d1_dat), .icpu_ack_o(d1_ack), .icpu_err_o(d1_err),
    .icpu_adr_o(d1_adr), .icpu_tag_o(d1_tag), .iwb_cyc_o(d1_cyc), .iwb_stb_o(d1_stb),
    .iwb_adr_o(d1_wadr), .iwb_sel_o(d1_sel), .iwb_we_o(d1_we), .iwb_cti_o(d1_cti),
    .iwb_dat_i(wb_dat), .iwb_ack_i(wb_ack), .iwb_err_i(wb_err), .iwb_rty_i(wb_rty));

  or1200_ifetch_resp #(.TIMEOUT_CYCLES(0)) dut2 (
    .clk(clk), .rst(rst), .icpu_cycstb_i(cycstb), .icpu_adr_i(adr), .icpu_tag_i(tag),
    .icpu_inv_i(inv), .icpu_dat_o(d2_dat), .icpu_ack_o(d2_ack), .icpu_err_o(d2_err),
    .icpu_adr_o(d2_adr), .icpu_tag_o(d2_tag), .iwb_cyc_o(d2_cyc), .iwb_stb_o(d2_stb),
    .iwb_adr_o(d2_wadr), .iwb_sel_o(d2_sel), .iwb_we_o(d2_we), .iwb_cti_o(d2_cti),
    .iwb_dat_i(wb_dat), .iwb_ack_i(wb_ack), .iwb_err_i(wb_err), .iwb_rty_i(wb_rty));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Slave configuration: wait states per strobe, retries before the final
  // answer, final answer kind (0 ack, 1 err, 2 silent) and read data.
  int          s_waits, s_rty, s_mode;
  logic [31:0] s_data;
  int          sw_cnt = 0;
  int          sr_cnt = 0;

  // Wishbone slave model, follows dut0's cycle.
  always @(negedge clk) begin
    wb_ack = 1'b0; wb_err = 1'b0; wb_rty = 1'b0;
    if (!d0_cyc) sr_cnt = 0;
    if (d0_cyc && d0_stb) begin
      if (sw_cnt < s_waits) sw_cnt++;
      else begin
        sw_cnt = 0;
        if (sr_cnt < s_rty) begin wb_rty = 1'b1; sr_cnt++; end
        else if (s_mode == 1) wb_err = 1'b1;
        else if (s_mode == 0) wb_ack = 1'b1;
      end
    end else sw_cnt = 0;
    wb_dat = wb_ack ? s_data : 32'hdead_beef;
  end

  // Reference buffer model.
  bit          m_valid;
  logic [29:0] m_adr;
  logic [31:0] m_dat;

  // Sampled view of the selected DUT.
  logic [31:0] g_dat, g_adr, g_wadr;
  logic        g_ack, g_err, g_cyc, g_stb;
  logic [3:0]  g_tag, g_sel;

  // Fetch observation results.
  int          r_lat, r_stb_low, r_cyc_last;
  logic        r_ack, r_err, r_cyc, r_cyc_resp, r_gap, r_after;
  logic [31:0] r_dat, r_adr, r_wadr;
  logic [3:0]  r_tag, r_sel;

  task automatic grab(input int d);
    case (d)
      1: begin g_dat = d1_dat; g_adr = d1_adr; g_ack = d1_ack; g_err = d1_err; g_tag = d1_tag;
               g_cyc = d1_cyc; g_stb = d1_stb; g_wadr = d1_wadr; g_sel = d1_sel; end
      2: begin g_dat = d2_dat; g_adr = d2_adr; g_ack = d2_ack; g_err = d2_err; g_tag = d2_tag;
               g_cyc = d2_cyc; g_stb = d2_stb; g_wadr = d2_wadr; g_sel = d2_sel; end
      default: begin g_dat = d0_dat; g_adr = d0_adr; g_ack = d0_ack; g_err = d0_err; g_tag = d0_tag;
               g_cyc = d0_cyc; g_stb = d0_stb; g_wadr = d0_wadr; g_sel = d0_sel; end
    endcase
  endtask

  task automatic set_slave(input int w, input int r, input int mode, input logic [31:0] dv);
    s_waits = w; s_rty = r; s_mode = mode; s_data = dv;
  endtask

  // One fetch on DUT d; inv pulse lands on edge inv_at (-1 none); bounded by limit cycles.
  task automatic do_fetch(input int d, input logic [31:0] a, input int inv_at, input int limit);
    bit dropped;
    dropped = 0;
    r_lat = 0; r_stb_low = 0; r_cyc_last = 0; r_ack = 0; r_err = 0; r_cyc = 0;
    r_cyc_resp = 0; r_gap = 0; r_after = 0; r_dat = '0; r_adr = '0; r_wadr = '0;
    r_tag = '0; r_sel = '0;
    @(negedge clk);
    adr = a; tag = 4'($urandom_range(0, 15)); cycstb = 1'b1; inv = (inv_at == 0);
    for (int c = 1; c <= limit; c++) begin
      @(negedge clk);
      inv = (inv_at == c);
      grab(d);
      if (g_ack || g_err) begin
        r_lat = c; r_ack = g_ack; r_err = g_err; r_dat = g_dat; r_adr = g_adr;
        r_tag = g_tag; r_cyc_resp = g_cyc;
        break;
      end
      if (g_cyc) begin
        if (!r_cyc) begin r_wadr = g_wadr; r_sel = g_sel; end
        if (dropped) r_gap = 1'b1;
        r_cyc = 1'b1; r_cyc_last = c;
        if (!g_stb) r_stb_low++;
      end else if (r_cyc) dropped = 1;
    end
    @(negedge clk);
    grab(d);
    r_after = g_ack || g_err;
    inv = 1'b0; cycstb = 1'b0;
  endtask

  task automatic pulse_inv;
    @(negedge clk); inv = 1'b1;
    @(negedge clk); inv = 1'b0;
    m_valid = 0;
  endtask

  task automatic reset_all;
    @(negedge clk);
    rst = 1'b0; cycstb = 1'b0; inv = 1'b0;
    set_slave(0, 0, 0, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    m_valid = 0;
  endtask

  task automatic test_reset;
    rst = 1'b1; cycstb = 1'b0; inv = 1'b0; adr = '0; tag = '0;
    set_slave(0, 0, 0, 32'h0);
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({d0_dat, d0_ack, d0_err, d0_adr, d0_tag, d0_cyc, d0_stb, d0_wadr, d0_sel, d0_we, d0_cti} !== '0) begin
      errors++; $display("FAIL reset_d0 got dat=%h adr=%h cyc=%b wadr=%h want all zero", d0_dat, d0_adr, d0_cyc, d0_wadr);
    end
    checks++;
    if ({d1_dat, d1_ack, d1_err, d1_adr, d1_tag, d1_cyc, d1_stb, d1_wadr, d1_sel, d1_we, d1_cti} !== '0) begin
      errors++; $display("FAIL reset_d1 got dat=%h adr=%h cyc=%b want all zero", d1_dat, d1_adr, d1_cyc);
    end
    checks++;
    if ({d2_dat, d2_ack, d2_err, d2_adr, d2_tag, d2_cyc, d2_stb, d2_wadr, d2_sel, d2_we, d2_cti} !== '0) begin
      errors++; $display("FAIL reset_d2 got dat=%h adr=%h cyc=%b want all zero", d2_dat, d2_adr, d2_cyc);
    end
    rst = 1'b1;
    m_valid = 0;
  endtask

  task automatic test_miss_hit;
    set_slave(0, 0, 0, 32'h1500_0000);
    do_fetch(0, 32'h100, -1, 40);
    checks++; if (r_ack !== 1'b1) begin errors++; $display("FAIL miss_ack got %b want 1", r_ack); end
    checks++; if (r_lat !== 2) begin errors++; $display("FAIL miss_lat got %0d want 2", r_lat); end
    checks++; if (r_adr !== 32'h100) begin errors++; $display("FAIL miss_adr got %h want 00000100", r_adr); end
    checks++; if (r_tag !== 4'h1) begin errors++; $display("FAIL miss_tag got %h want 1", r_tag); end
    checks++; if (r_dat !== 32'h1500_0000) begin errors++; $display("FAIL miss_dat got %h want 15000000", r_dat); end
    checks++; if ({r_wadr, r_sel} !== {32'h100, 4'hf}) begin errors++; $display("FAIL miss_wb got adr=%h sel=%h want 00000100 f", r_wadr, r_sel); end
    set_slave(0, 0, 0, 32'h0bad_0bad);
    do_fetch(0, 32'h102, -1, 40);
    checks++; if (r_lat !== 1) begin errors++; $display("FAIL hit_lat got %0d want 1", r_lat); end
    checks++; if (r_cyc !== 1'b0) begin errors++; $display("FAIL hit_nocyc got cyc=%b want 0", r_cyc); end
    checks++; if ({r_dat, r_adr} !== {32'h1500_0000, 32'h100}) begin errors++; $display("FAIL hit_dat got %h/%h want 15000000/00000100", r_dat, r_adr); end
  endtask

  task automatic test_invalidate;
    pulse_inv();
    set_slave(0, 0, 0, 32'h1500_0000);
    do_fetch(0, 32'h100, -1, 40);
    checks++; if ({r_cyc, r_lat} !== {1'b1, 32'd2}) begin errors++; $display("FAIL inv_miss got cyc=%b lat=%0d want 1/2", r_cyc, r_lat); end
    set_slave(3, 0, 0, 32'haaaa_5555);
    do_fetch(0, 32'h200, 2, 40);
    checks++; if ({r_ack, r_dat} !== {1'b1, 32'haaaa_5555}) begin errors++; $display("FAIL inv_outst got ack=%b dat=%h want 1/aaaa5555", r_ack, r_dat); end
    set_slave(0, 0, 0, 32'haaaa_5555);
    do_fetch(0, 32'h200, -1, 40);
    checks++; if ({r_cyc, r_lat} !== {1'b1, 32'd2}) begin errors++; $display("FAIL inv_refetch got cyc=%b lat=%0d want 1/2", r_cyc, r_lat); end
  endtask

  task automatic test_retry;
    set_slave(0, 1, 0, 32'h1234_5678);
    do_fetch(0, 32'h140, -1, 40);
    checks++; if ({r_ack, r_lat} !== {1'b1, 32'd4}) begin errors++; $display("FAIL rty_lat got ack=%b lat=%0d want 1/4", r_ack, r_lat); end
    checks++; if ({r_stb_low, r_gap} !== {32'd1, 1'b0}) begin errors++; $display("FAIL rty_stb got stblow=%0d gap=%b want 1/0", r_stb_low, r_gap); end
  endtask

  task automatic test_error;
    set_slave(0, 0, 0, 32'h0000_0180);
    do_fetch(0, 32'h180, -1, 40);
    set_slave(1, 0, 1, 32'h0);
    do_fetch(0, 32'h1c0, -1, 40);
    checks++; if ({r_err, r_ack, r_tag} !== {1'b1, 1'b0, 4'hb}) begin errors++; $display("FAIL err_flags got err=%b ack=%b tag=%h want 1/0/b", r_err, r_ack, r_tag); end
    checks++; if ({r_dat, r_lat} !== {32'h0, 32'd3}) begin errors++; $display("FAIL err_dat got dat=%h lat=%0d want 0/3", r_dat, r_lat); end
    set_slave(0, 0, 0, 32'h0000_0180);
    do_fetch(0, 32'h180, -1, 40);
    checks++; if (r_cyc !== 1'b1) begin errors++; $display("FAIL err_bufinv got cyc=%b want 1", r_cyc); end
  endtask

  task automatic test_timeout;
    reset_all();
    set_slave(0, 0, 2, 32'h0);
    do_fetch(1, 32'h240, -1, 20);
    checks++; if ({r_err, r_lat} !== {1'b1, 32'(TO1 + 1)}) begin errors++; $display("FAIL to_err got err=%b lat=%0d want 1/%0d", r_err, r_lat, TO1 + 1); end
    checks++; if ({r_tag, r_dat} !== {4'hb, 32'h0}) begin errors++; $display("FAIL to_tag got tag=%h dat=%h want b/0", r_tag, r_dat); end
    checks++; if ({r_cyc_last, r_cyc_resp} !== {32'(TO1), 1'b0}) begin errors++; $display("FAIL to_cyc got last=%0d atresp=%b want %0d/0", r_cyc_last, r_cyc_resp, TO1); end
    reset_all();
    set_slave(0, 0, 2, 32'h0);
    do_fetch(2, 32'h240, -1, 300);
    checks++; if ({r_lat, r_err} !== {32'd0, 1'b0}) begin errors++; $display("FAIL noto_resp got lat=%0d err=%b want none", r_lat, r_err); end
    checks++; if (g_cyc !== 1'b1) begin errors++; $display("FAIL noto_cyc got cyc=%b want 1", g_cyc); end
    reset_all();
  endtask

  task automatic test_abort;
    bit resp; logic c6, c7;
    resp = 0; c6 = 0; c7 = 0;
    set_slave(5, 0, 0, 32'h3a3a_3a3a);
    @(negedge clk); adr = 32'h3a0; cycstb = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      grab(0);
      if (g_ack || g_err) resp = 1;
      if (c == 6) c6 = g_cyc;
      if (c == 7) c7 = g_cyc;
      if (c == 3) cycstb = 1'b0;
    end
    checks++; if (resp !== 1'b0) begin errors++; $display("FAIL abort_noresp got resp=%b want 0", resp); end
    checks++; if ({c6, c7} !== 2'b10) begin errors++; $display("FAIL abort_drain got cyc6=%b cyc7=%b want 1/0", c6, c7); end
    set_slave(0, 0, 0, 32'h3a3a_3a3a);
    do_fetch(0, 32'h3a0, -1, 40);
    checks++; if ({r_cyc, r_lat} !== {1'b1, 32'd2}) begin errors++; $display("FAIL abort_refetch got cyc=%b lat=%0d want 1/2", r_cyc, r_lat); end
  endtask

  task automatic test_reset_mid;
    set_slave(0, 0, 0, 32'h0101_0101);
    do_fetch(0, 32'h100, -1, 40);
    do_fetch(0, 32'h100, -1, 40);
    checks++; if (r_lat !== 1) begin errors++; $display("FAIL rstmid_prehit got lat=%0d want 1", r_lat); end
    set_slave(10, 0, 0, 32'h0);
    @(negedge clk); adr = 32'h300; cycstb = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 grab(0);
    checks++; if ({g_cyc, g_stb, g_ack, g_err} !== 4'b0) begin errors++; $display("FAIL rstmid_async got cyc=%b stb=%b ack=%b err=%b want 0", g_cyc, g_stb, g_ack, g_err); end
    cycstb = 1'b0;
    @(negedge clk); rst = 1'b1; m_valid = 0;
    set_slave(0, 0, 0, 32'h0101_0101);
    do_fetch(0, 32'h100, -1, 40);
    checks++; if ({r_cyc, r_lat} !== {1'b1, 32'd2}) begin errors++; $display("FAIL rstmid_miss got cyc=%b lat=%0d want 1/2", r_cyc, r_lat); end
  endtask

  task automatic test_random;
    logic [31:0] a, dv, exp_dat;
    int w, r, inv_at, k, exp_lat;
    bit e, hit, exp_err;
    reset_all();
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 4) == 0) pulse_inv();
      a  = 32'h100 + (32'($urandom_range(0, 3)) << 2) + 32'($urandom_range(0, 3));
      dv = $urandom;
      w  = $urandom_range(0, 3);
      r  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      e  = ($urandom_range(0, 7) == 0);
      k  = $urandom_range(0, 9);
      inv_at = (k == 0) ? 0 : (k == 1) ? 1 : -1;
      set_slave(w, r, e ? 1 : 0, dv);
      hit = m_valid && (m_adr == a[31:2]) && (inv_at != 0);
      if (hit) begin
        exp_lat = 1; exp_err = 0; exp_dat = m_dat;
      end else begin
        exp_lat = 1 + (r + 1) * (1 + w) + r;
        exp_err = e;
        exp_dat = e ? 32'h0 : dv;
        if (e) m_valid = 0;
        else begin m_valid = 1; m_adr = a[31:2]; m_dat = dv; end
      end
      if (inv_at == 0 || inv_at == 1) m_valid = 0;
      do_fetch(0, a, inv_at, 40);
      checks++; if (r_lat !== exp_lat) begin errors++; $display("FAIL rnd_lat i=%0d got %0d want %0d", i, r_lat, exp_lat); end
      checks++; if ({r_ack, r_err} !== {!exp_err, exp_err}) begin errors++; $display("FAIL rnd_kind i=%0d got ack=%b err=%b want err=%b", i, r_ack, r_err, exp_err); end
      checks++; if (r_dat !== exp_dat) begin errors++; $display("FAIL rnd_dat i=%0d got %h want %h", i, r_dat, exp_dat); end
      checks++; if (r_adr !== {a[31:2], 2'b00}) begin errors++; $display("FAIL rnd_adr i=%0d got %h want %h", i, r_adr, {a[31:2], 2'b00}); end
      checks++; if (r_tag !== (exp_err ? 4'hb : 4'h1)) begin errors++; $display("FAIL rnd_tag i=%0d got %h want %h", i, r_tag, exp_err ? 4'hb : 4'h1); end
      checks++; if (r_cyc !== !hit) begin errors++; $display("FAIL rnd_bus i=%0d got cyc=%b want %b", i, r_cyc, !hit); end
      checks++; if (r_after !== 1'b0) begin errors++; $display("FAIL rnd_pulse i=%0d response held past one cycle", i); end
      checks++; if ({r_stb_low, r_gap} !== {(hit ? 32'd0 : 32'(r)), 1'b0}) begin errors++; $display("FAIL rnd_rty i=%0d got stblow=%0d gap=%b want %0d/0", i, r_stb_low, r_gap, hit ? 0 : r); end
    end
  endtask

  initial begin
    test_reset();
    test_miss_hit();
    test_invalidate();
    test_retry();
    test_error();
    test_abort();
    test_reset_mid();
    test_timeout();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
